// File: rtl/phy_tx_sched.sv
// PHY transmit link bring-up FSM and four-lane round-robin byte scheduler.
// Define PHY_TX_SCHED_SKP_EN to insert periodic SKP_SYM skip slots in ACTIVE.
module phy_tx_sched #(
  parameter int          TRAIN_LEN    = 16,
  parameter int          LOCK_TIMEOUT = 64,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter int          SKP_PERIOD   = 256,
  parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_0p,
  input  logic [7:0] data_1p,
  input  logic [7:0] data_2p,
  input  logic [7:0] data_3p,
  input  logic       valid_0p,
  input  logic       valid_1p,
  input  logic       valid_2p,
  input  logic       valid_3p,
  input  logic       idle_in,
  output logic       grant_0,
  output logic       grant_1,
  output logic       grant_2,
  output logic       grant_3,
  output logic [7:0] data_000,
  output logic       valid_000,
  output logic       inserter,
  output logic [1:0] link_state,
  output logic       lock_err
);

  localparam logic [1:0] S_TRAIN = 2'b00;
  localparam logic [1:0] S_WAIT  = 2'b01;
  localparam logic [1:0] S_ACT   = 2'b10;

  localparam int CMAX = (TRAIN_LEN > LOCK_TIMEOUT) ?
                        TRAIN_LEN : LOCK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic          set_err;

  logic [3:0]    vld;
  logic [7:0]    din [4];
  logic [3:0]    gnt;
  logic [1:0]    gsel;
  logic [1:0]    idx;
  logic [1:0]    last_q;
  logic          skip_slot;
  logic          arb_en;
  logic [7:0]    d_nxt;
  logic          v_nxt;

  assign vld    = {valid_3p, valid_2p, valid_1p, valid_0p};
  assign din[0] = data_0p;
  assign din[1] = data_1p;
  assign din[2] = data_2p;
  assign din[3] = data_3p;

  assign grant_0    = gnt[0];
  assign grant_1    = gnt[1];
  assign grant_2    = gnt[2];
  assign grant_3    = gnt[3];
  assign link_state = state_q;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q  <= S_TRAIN;
      cnt_q    <= '0;
      lock_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q != S_ACT)
        cnt_q <= cnt_q + CW'(1);
      if (set_err)
        lock_err <= 1'b1;
    end
  end

  // Unused encoding 11 behaves as TRAIN.
  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (idle_in) begin
          state_d = S_ACT;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = S_TRAIN;
          set_err = 1'b1;
        end
      end
      S_ACT: state_d = S_ACT;
      default: begin
        if (cnt_q == CW'(TRAIN_LEN - 1))
          state_d = S_WAIT;
        else
          state_d = S_TRAIN;
      end
    endcase
  end

`ifdef PHY_TX_SCHED_SKP_EN
  localparam int SW = (SKP_PERIOD > 1) ? $clog2(SKP_PERIOD) : 1;

  logic [SW-1:0] skp_q;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset)
      skp_q <= '0;
    else if (state_q != S_ACT)
      skp_q <= '0;
    else if (skp_q == SW'(SKP_PERIOD - 1))
      skp_q <= '0;
    else
      skp_q <= skp_q + SW'(1);
  end

  assign skip_slot = (state_q == S_ACT) &&
                     (skp_q == SW'(SKP_PERIOD - 1));
`else
  logic unused_skp;
  assign unused_skp = ^{SKP_SYM, SKP_PERIOD[0]};
  assign skip_slot  = 1'b0;
`endif

  assign arb_en = (state_q == S_ACT) && !skip_slot;

  // Search last+1 .. last+4; the fourth step wraps back onto last.
  always_comb begin
    gnt  = '0;
    gsel = last_q;
    idx  = last_q;
    if (arb_en) begin
      for (int k = 1; k < 5; k++) begin
        idx = last_q + 2'(k);
        if (gnt == '0 && vld[idx]) begin
          gnt[idx] = 1'b1;
          gsel     = idx;
        end
      end
    end
  end

  always_comb begin
    d_nxt = COM_SYM;
    v_nxt = 1'b0;
    if (skip_slot) begin
      d_nxt = SKP_SYM;
      v_nxt = 1'b1;
    end else if (gnt != '0) begin
      d_nxt = din[gsel];
      v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      data_000  <= 8'h00;
      valid_000 <= 1'b0;
      inserter  <= 1'b1;
      last_q    <= 2'd3;
    end else begin
      data_000  <= d_nxt;
      valid_000 <= v_nxt;
      inserter  <= (state_d != S_ACT);
      if (gnt != '0)
        last_q <= gsel;
    end
  end

endmodule

// File: tb/tb_phy_tx_sched.sv
// Bench for phy_tx_sched: cycle model plus directed bring-up/arbitration vectors.
// Skip-slot expectations follow PHY_TX_SCHED_SKP_EN with SKP_PERIOD=8.
module tb_phy_tx_sched;

  localparam int         TL   = 16;
  localparam int         LT   = 64;
  localparam int         SKP  = 8;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] SSYM = 8'h1C;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] data_0p, data_1p, data_2p, data_3p;
  logic       valid_0p, valid_1p, valid_2p, valid_3p;
  logic       idle_in;
  logic       grant_0, grant_1, grant_2, grant_3;
  logic [7:0] data_000;
  logic       valid_000;
  logic       inserter;
  logic [1:0] link_state;
  logic       lock_err;

  int n_vec = 0;
  int n_err = 0;

  phy_tx_sched #(
    .TRAIN_LEN(TL), .LOCK_TIMEOUT(LT), .COM_SYM(COM),
    .SKP_PERIOD(SKP), .SKP_SYM(SSYM)
  ) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_0p(data_0p), .data_1p(data_1p),
    .data_2p(data_2p), .data_3p(data_3p),
    .valid_0p(valid_0p), .valid_1p(valid_1p),
    .valid_2p(valid_2p), .valid_3p(valid_3p),
    .idle_in(idle_in),
    .grant_0(grant_0), .grant_1(grant_1),
    .grant_2(grant_2), .grant_3(grant_3),
    .data_000(data_000), .valid_000(valid_000),
    .inserter(inserter), .link_state(link_state),
    .lock_err(lock_err)
  );

  always #5 clk_4f = ~clk_4f;

  // Model: 0 TRAIN, 1 WAIT_LOCK, 2 ACTIVE; m_cnt = cycles spent in state.
  int         m_state = 0;
  int         m_cnt   = 0;
  int         m_last  = 3;
  int         m_skp   = 0;
  logic       m_err   = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ins   = 1'b1;

  logic [3:0] vin;
  logic [3:0] gv;
  assign vin = {valid_3p, valid_2p, valid_1p, valid_0p};
  assign gv  = {grant_3, grant_2, grant_1, grant_0};

  function automatic logic skip_now();
`ifdef PHY_TX_SCHED_SKP_EN
    return (m_state == 2) && (m_skp == SKP - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    int lane;
    g = 4'b0;
    if (m_state == 2 && !skip_now()) begin
      for (int k = 1; k <= 4; k++) begin
        lane = (m_last + k) % 4;
        if (g == 4'b0 && vin[lane]) g[lane] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [7:0] lane_data(int l);
    case (l)
      0: return data_0p;
      1: return data_1p;
      2: return data_2p;
      default: return data_3p;
    endcase
  endfunction

  always @(posedge clk_4f or posedge reset) begin
    logic [3:0] g;
    logic       sk;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_last = 3; m_skp = 0;
      m_err = 1'b0; m_data = 8'h00; m_valid = 1'b0;
      m_ins = 1'b1;
    end else begin
      g  = exp_grant();
      sk = skip_now();
      m_data  = COM;
      m_valid = 1'b0;
      if (m_state == 2) begin
        if (sk) begin
          m_data  = SSYM;
          m_valid = 1'b1;
        end else begin
          for (int l = 0; l < 4; l++) begin
            if (g[l]) begin
              m_data  = lane_data(l);
              m_valid = 1'b1;
              m_last  = l;
            end
          end
        end
        m_skp = (m_skp + 1) % SKP;
      end else if (m_state == 1) begin
        if (idle_in) begin
          m_state = 2; m_cnt = 0; m_skp = 0;
        end else if (m_cnt == LT - 1) begin
          m_state = 0; m_cnt = 0; m_err = 1'b1;
        end else begin
          m_cnt++;
        end
      end else begin
        if (m_cnt == TL - 1) begin
          m_state = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      m_ins = (m_state != 2);
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_4f) begin
    chk("grant",      int'(gv),         int'(exp_grant()));
    chk("data_000",   int'(data_000),   int'(m_data));
    chk("valid_000",  int'(valid_000),  int'(m_valid));
    chk("inserter",   int'(inserter),   int'(m_ins));
    chk("link_state", int'(link_state), m_state);
    chk("lock_err",   int'(lock_err),   int'(m_err));
  end

  task automatic nxt();
    @(negedge clk_4f);
    #1;
  endtask

  int gcount;
  int scount;

  initial begin
    reset = 1'b1; idle_in = 1'b0;
    {valid_0p, valid_1p, valid_2p, valid_3p} = 4'b0;
    {data_0p, data_1p, data_2p, data_3p} = 32'h0;
    nxt(); nxt();
    chk("rst_data", int'(data_000), 'h00);
    chk("rst_ins",  int'(inserter), 1);
    chk("rst_link", int'(link_state), 0);
    chk("rst_err",  int'(lock_err), 0);
    reset = 1'b0;

    // Lock never arrives: 16 TRAIN, 64 WAIT_LOCK, back to TRAIN.
    repeat (15) nxt();
    chk("train_end", int'(link_state), 0);
    nxt();
    chk("wait_start", int'(link_state), 1);
    repeat (63) nxt();
    chk("wait_end", int'(link_state), 1);
    chk("wait_noerr", int'(lock_err), 0);
    nxt();
    chk("timeout_link", int'(link_state), 0);
    chk("timeout_err", int'(lock_err), 1);
    chk("timeout_data", int'(data_000), 'hBC);
    chk("timeout_valid", int'(valid_000), 0);

    // Fresh bring-up: lock on 3rd WAIT_LOCK cycle.
    reset = 1'b1; #1; reset = 1'b0;
    repeat (16) nxt();
    chk("bu_wait", int'(link_state), 1);
    nxt(); nxt();
    idle_in = 1'b1;
    nxt();
    chk("bu_active", int'(link_state), 2);
    chk("bu_ins", int'(inserter), 0);
    chk("bu_err", int'(lock_err), 0);
    idle_in = 1'b0;

    // All four lanes held: rotation 0,1,2,3,0.
    data_0p = 8'hA0; data_1p = 8'hA1;
    data_2p = 8'hA2; data_3p = 8'hA3;
    {valid_3p, valid_2p, valid_1p, valid_0p} = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rot_grant", int'(gv), 1 << (i % 4));
      nxt();
      chk("rot_data", int'(data_000), 'hA0 + (i % 4));
      chk("rot_valid", int'(valid_000), 1);
    end

    // Only lane 2 requests.
    {valid_3p, valid_2p, valid_1p, valid_0p} = 4'b0100;
    data_2p = 8'h55;
    for (int i = 0; i < 3; i++) begin
      nxt();
`ifndef PHY_TX_SCHED_SKP_EN
      chk("sparse_data", int'(data_000), 'h55);
`endif
    end
    {valid_3p, valid_2p, valid_1p, valid_0p} = 4'b0;
    nxt();
    chk("drop_data", int'(data_000), 'hBC);
    chk("drop_valid", int'(valid_000), 0);

    // Reset during grant_1.
    {valid_3p, valid_2p, valid_1p, valid_0p} = 4'b0010;
    data_1p = 8'h77;
    #1;
    chk("pre_rst_g1", int'(grant_1), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", int'(gv), 0);
    chk("mid_rst_data", int'(data_000), 'h00);
    chk("mid_rst_valid", int'(valid_000), 0);
    chk("mid_rst_ins", int'(inserter), 1);
    chk("mid_rst_link", int'(link_state), 0);
    {valid_3p, valid_2p, valid_1p, valid_0p} = 4'hF;
    reset = 1'b0;
    repeat (16) nxt();
    idle_in = 1'b1;
    nxt();
    idle_in = 1'b0;
    chk("re_active", int'(link_state), 2);
    #1;
    chk("re_first_g0", int'(gv), 1);

    // Lane 0 alone for 16 ACTIVE cycles.
    {valid_3p, valid_2p, valid_1p} = 3'b0;
    data_0p = 8'h11;
    gcount = 0;
    scount = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      gcount += int'(grant_0);
      nxt();
      if (data_000 == SSYM && valid_000) scount++;
    end
`ifdef PHY_TX_SCHED_SKP_EN
    chk("skp_grants", gcount, 14);
    chk("skp_slots", scount, 2);
`else
    chk("noskp_grants", gcount, 16);
    chk("noskp_slots", scount, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
